// File: rtl/comp_stream_tracker.sv
// comp_stream_tracker
//   Parametrised WIDTH-bit comparator behind a valid/ready handshake with one
//   registered output stage. Mode 0 compares in0 against in1. Mode 1 tracks the
//   running minimum, running maximum and a saturating sample count over a stream
//   of in0 values. Signedness is chosen per transaction.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   in_valid, in_ready  input handshake (in_ready = ~out_valid | out_ready)
//   in0, in1            operands (in0 is the stream sample in track mode)
//   is_signed, mode     per-transaction compare signedness and mode select
//   clear               one-cycle pulse that empties the tracker
//   out_valid, out_ready  output handshake
//   GT, LT, ET          registered result flags
//   min_val, max_val    running extremes
//   sample_cnt          samples accepted since clear or reset (saturating)

module comp_stream_tracker #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic             is_signed,
   input  logic             mode,
   input  logic             clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             GT,
   output logic             LT,
   output logic             ET,
   output logic [WIDTH-1:0] min_val,
   output logic [WIDTH-1:0] max_val,
   output logic [CNT_W-1:0] sample_cnt
);

   typedef enum logic [0:0] {StEmpty, StTracking} state_e;

   state_e state_q;

   logic       accept;
   logic [1:0] pair_cmp;
   logic [1:0] max_cmp;
   logic [1:0] min_cmp;
   logic       new_max;
   logic       new_min;
   logic       cnt_full;

   // Returns {a > b, a < b}. Flipping the MSB maps two's-complement order onto
   // unsigned order, so one magnitude comparator serves both signednesses.
   function automatic logic [1:0] cmp(input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b,
                                      input logic             sgn);
      logic [WIDTH-1:0] ua;
      logic [WIDTH-1:0] ub;
      ua = {a[WIDTH-1] ^ sgn, a[WIDTH-2:0]};
      ub = {b[WIDTH-1] ^ sgn, b[WIDTH-2:0]};
      return {ua > ub, ua < ub};
   endfunction

   always_comb begin
      in_ready = ~out_valid | out_ready;
      accept   = in_valid & in_ready;
      pair_cmp = cmp(in0, in1, is_signed);
      max_cmp  = cmp(in0, max_val, is_signed);
      min_cmp  = cmp(in0, min_val, is_signed);
      new_max  = max_cmp[1];
      new_min  = min_cmp[0];
      cnt_full = &sample_cnt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StEmpty;
         out_valid  <= 1'b0;
         GT         <= 1'b0;
         LT         <= 1'b0;
         ET         <= 1'b0;
         min_val    <= '0;
         max_val    <= '0;
         sample_cnt <= '0;
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         // A mode-1 accept in the same cycle overrides these below and becomes
         // the first sample of a fresh run.
         if (clear) begin
            state_q    <= StEmpty;
            min_val    <= '0;
            max_val    <= '0;
            sample_cnt <= '0;
         end

         if (accept) begin
            if (!mode) begin
               GT <= pair_cmp[1];
               LT <= pair_cmp[0];
               ET <= ~|pair_cmp;
            end else if (state_q == StEmpty || clear) begin
               state_q    <= StTracking;
               min_val    <= in0;
               max_val    <= in0;
               sample_cnt <= CNT_W'(1);
               GT         <= 1'b0;
               LT         <= 1'b0;
               ET         <= 1'b1;
            end else begin
               if (new_max) max_val <= in0;
               if (new_min) min_val <= in0;
               if (!cnt_full) sample_cnt <= sample_cnt + CNT_W'(1);
               // Mixed signedness can make a sample beat both extremes; the
               // registers follow both compares but the flags stay exclusive.
               GT <= new_max;
               LT <= new_min & ~new_max;
               ET <= ~new_max & ~new_min;
            end
         end
      end
   end

endmodule

// File: tb/tb_comp_stream_tracker.sv
// Directed and table-driven checks for comp_stream_tracker. Three instances
// share one stimulus bus: WIDTH=16 (main checks), WIDTH=8 with CNT_W=2
// (counter saturation) and WIDTH=32 (random pair sweep).

module tb_comp_stream_tracker;

   logic        clk = 1'b0;
   logic        rst, in_valid, is_signed, mode, clear, out_ready;
   logic [31:0] in0, in1;

   logic        rdy16, ov16, gt16, lt16, et16;
   logic [15:0] mn16, mx16;
   logic [7:0]  cnt16;
   logic        rdy8, ov8, gt8, lt8, et8;
   logic [7:0]  mn8, mx8;
   logic [1:0]  cnt8;
   logic        rdy32, ov32, gt32, lt32, et32;
   logic [31:0] mn32, mx32;
   logic [7:0]  cnt32;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   comp_stream_tracker #(.WIDTH(16), .CNT_W(8)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16),
      .in0(in0[15:0]), .in1(in1[15:0]), .is_signed(is_signed), .mode(mode),
      .clear(clear), .out_valid(ov16), .out_ready(out_ready),
      .GT(gt16), .LT(lt16), .ET(et16),
      .min_val(mn16), .max_val(mx16), .sample_cnt(cnt16));

   comp_stream_tracker #(.WIDTH(8), .CNT_W(2)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
      .in0(in0[7:0]), .in1(in1[7:0]), .is_signed(is_signed), .mode(mode),
      .clear(clear), .out_valid(ov8), .out_ready(out_ready),
      .GT(gt8), .LT(lt8), .ET(et8),
      .min_val(mn8), .max_val(mx8), .sample_cnt(cnt8));

   comp_stream_tracker #(.WIDTH(32), .CNT_W(8)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
      .in0(in0), .in1(in1), .is_signed(is_signed), .mode(mode),
      .clear(clear), .out_valid(ov32), .out_ready(out_ready),
      .GT(gt32), .LT(lt32), .ET(et32),
      .min_val(mn32), .max_val(mx32), .sample_cnt(cnt32));

   typedef struct {
      logic        m;
      logic        s;
      logic        c;
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  fl;   // {GT, LT, ET}
      logic [15:0] mn;
      logic [15:0] mx;
      logic [7:0]  cnt;
   } vec_t;

   vec_t tv[14];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference compare: values are widened to signed 64-bit integers.
   function automatic logic [2:0] ref_flags(input logic [31:0] a, input logic [31:0] b,
                                            input int w, input bit s);
      longint va, vb, mask;
      mask = (longint'(1) <<< w) - 1;
      va = longint'({32'd0, a}) & mask;
      vb = longint'({32'd0, b}) & mask;
      if (s && va[w-1]) va = va - (longint'(1) <<< w);
      if (s && vb[w-1]) vb = vb - (longint'(1) <<< w);
      return {va > vb, va < vb, va == vb};
   endfunction

   task automatic send(input logic m, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic c);
      in_valid = 1'b1; mode = m; is_signed = s; in0 = a; in1 = b; clear = c;
      step();
      in_valid = 1'b0; clear = 1'b0;
   endtask

   task automatic chk_track(input string nm, input logic [15:0] mn, input logic [15:0] mx,
                            input logic [7:0] cnt);
      chk({nm, " min"}, 64'(mn16), 64'(mn));
      chk({nm, " max"}, 64'(mx16), 64'(mx));
      chk({nm, " cnt"}, 64'(cnt16), 64'(cnt));
   endtask

   initial begin
      logic [2:0] e;
      tv[0]  = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 3'b100, 16'h0000, 16'h0000, 8'd0};
      tv[1]  = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0001, 3'b010, 16'h0000, 16'h0000, 8'd0};
      tv[2]  = '{1'b0, 1'b1, 1'b0, 16'h8000, 16'h8001, 3'b010, 16'h0000, 16'h0000, 8'd0};
      tv[3]  = '{1'b0, 1'b1, 1'b0, 16'h7FFF, 16'h7FFF, 3'b001, 16'h0000, 16'h0000, 8'd0};
      tv[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 3'b010, 16'h0000, 16'h0000, 8'd0};
      tv[5]  = '{1'b1, 1'b1, 1'b0, 16'h0005, 16'h0000, 3'b001, 16'h0005, 16'h0005, 8'd1};
      tv[6]  = '{1'b1, 1'b1, 1'b0, 16'hFFFD, 16'h0000, 3'b010, 16'hFFFD, 16'h0005, 8'd2};
      tv[7]  = '{1'b1, 1'b1, 1'b0, 16'h000A, 16'h0000, 3'b100, 16'hFFFD, 16'h000A, 8'd3};
      tv[8]  = '{1'b1, 1'b1, 1'b0, 16'h0004, 16'h0000, 3'b001, 16'hFFFD, 16'h000A, 8'd4};
      tv[9]  = '{1'b0, 1'b1, 1'b0, 16'h0003, 16'h0004, 3'b010, 16'hFFFD, 16'h000A, 8'd4};
      tv[10] = '{1'b1, 1'b1, 1'b1, 16'h0007, 16'h0000, 3'b001, 16'h0007, 16'h0007, 8'd1};
      tv[11] = '{1'b1, 1'b0, 1'b0, 16'h0007, 16'h0000, 3'b001, 16'h0007, 16'h0007, 8'd2};
      tv[12] = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 3'b100, 16'h0007, 16'hFFFF, 8'd3};
      tv[13] = '{1'b1, 1'b0, 1'b0, 16'h0003, 16'h0000, 3'b010, 16'h0003, 16'hFFFF, 8'd4};

      rst = 1'b1; in_valid = 1'b0; is_signed = 1'b0; mode = 1'b0; clear = 1'b0;
      out_ready = 1'b1; in0 = '0; in1 = '0;
      step();
      step();
      rst = 1'b0;
      chk("reset out_valid", 64'(ov16), 64'd0);
      chk("reset flags", 64'({gt16, lt16, et16}), 64'd0);
      chk_track("reset", 16'h0, 16'h0, 8'd0);
      chk("reset in_ready", 64'(rdy16), 64'd1);

      // Back-to-back accepts with out_ready held high: one result per cycle.
      for (int i = 0; i < 14; i++) begin
         in_valid = 1'b1; mode = tv[i].m; is_signed = tv[i].s; clear = tv[i].c;
         in0 = {16'h0, tv[i].a}; in1 = {16'h0, tv[i].b};
         step();
         chk($sformatf("vec%0d out_valid", i), 64'(ov16), 64'd1);
         chk($sformatf("vec%0d flags", i), 64'({gt16, lt16, et16}), 64'(tv[i].fl));
         chk_track($sformatf("vec%0d", i), tv[i].mn, tv[i].mx, tv[i].cnt);
      end
      in_valid = 1'b0; clear = 1'b0;

      // Narrow instance: 4 samples since clear saturate a 2-bit count, and the
      // 4th sample still lowers the minimum.
      chk("sat cnt", 64'(cnt8), 64'd3);
      chk("sat min", 64'(mn8), 64'h03);
      chk("sat max", 64'(mx8), 64'hFF);

      // clear alone: tracker empties, pending result and flags untouched.
      out_ready = 1'b0; clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clear out_valid", 64'(ov16), 64'd1);
      chk("clear flags", 64'({gt16, lt16, et16}), 64'b010);
      chk_track("clear", 16'h0, 16'h0, 8'd0);

      // Drain, then backpressure with a second transaction waiting.
      out_ready = 1'b1;
      step();
      chk("drain out_valid", 64'(ov16), 64'd0);
      out_ready = 1'b0;
      send(1'b0, 1'b0, 32'd5, 32'd3, 1'b0);
      chk("bp first flags", 64'({gt16, lt16, et16}), 64'b100);
      in_valid = 1'b1; in0 = 32'd1; in1 = 32'd2;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("bp%0d in_ready", k), 64'(rdy16), 64'd0);
         step();
         chk($sformatf("bp%0d out_valid", k), 64'(ov16), 64'd1);
         chk($sformatf("bp%0d flags", k), 64'({gt16, lt16, et16}), 64'b100);
      end
      out_ready = 1'b1;
      step();
      chk("bp held sample", 64'({ov16, gt16, lt16, et16}), 64'b1010);
      in0 = 32'd2; in1 = 32'd2;
      step();
      chk("bp next sample", 64'({ov16, gt16, lt16, et16}), 64'b1001);
      in_valid = 1'b0;
      step();
      chk("bp idle out_valid", 64'(ov16), 64'd0);

      // clear with a mode-0 accept: pair result registered, tracker emptied.
      send(1'b1, 1'b0, 32'd9, 32'd0, 1'b0);
      chk_track("pre m0clr", 16'd9, 16'd9, 8'd1);
      send(1'b0, 1'b0, 32'd3, 32'd3, 1'b1);
      chk("m0clr flags", 64'({ov16, gt16, lt16, et16}), 64'b1001);
      chk_track("m0clr", 16'd0, 16'd0, 8'd0);
      send(1'b1, 1'b0, 32'd4, 32'd0, 1'b0);
      chk("m0clr first flags", 64'({gt16, lt16, et16}), 64'b001);
      chk_track("m0clr first", 16'd4, 16'd4, 8'd1);
      send(1'b1, 1'b0, 32'd8, 32'd0, 1'b0);
      chk_track("m0clr second", 16'd4, 16'd8, 8'd2);

      // Reset mid-stream with a pending, unconsumed result.
      out_ready = 1'b0;
      step();
      chk("pre rst out_valid", 64'(ov16), 64'd1);
      rst = 1'b1; in_valid = 1'b1; mode = 1'b1; in0 = 32'd20;
      step();
      rst = 1'b0; in_valid = 1'b0;
      chk("rst outputs", 64'({ov16, gt16, lt16, et16, cnt16}), 64'd0);
      chk("rst min/max", 64'({mn16, mx16}), 64'd0);
      chk("rst in_ready", 64'(rdy16), 64'd1);
      out_ready = 1'b1;
      send(1'b1, 1'b1, 32'd6, 32'd0, 1'b0);
      chk("post rst flags", 64'({gt16, lt16, et16}), 64'b001);
      chk_track("post rst", 16'd6, 16'd6, 8'd1);

      // Random pairwise sweep on all three widths.
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a, b;
         bit s;
         a = $urandom();
         b = (i % 5 == 0) ? a : $urandom();
         s = 1'($urandom_range(0, 1));
         send(1'b0, s, a, b, 1'b0);
         e = ref_flags(a, b, 8, s);
         chk($sformatf("rnd%0d w8", i), 64'({gt8, lt8, et8}), 64'(e));
         e = ref_flags(a, b, 16, s);
         chk($sformatf("rnd%0d w16", i), 64'({gt16, lt16, et16}), 64'(e));
         e = ref_flags(a, b, 32, s);
         chk($sformatf("rnd%0d w32", i), 64'({gt32, lt32, et32}), 64'(e));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
